bcd_gray_arbiter: RTL

BCD_GRAY_ARBITER -- requirements
Module: bcd_gray_arbiter

---
 rtl/bcd_gray_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/bcd_gray_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bcd_gray_arbiter: two-requester BCD->Gray converter, one-entry output. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module bcd_gray_arbiter #(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_bcd,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_bcd,
  output logic       req1_ready,
  output logic       out_valid,
  output logic [3:0] out_gray,
  output logic       out_id,
  output logic       out_err,
  input  logic       out_ready,
  output logic [7:0] err_cnt
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] out_gray_q, out_gray_d;
  logic       out_id_q, out_id_d;
  logic       out_err_q, out_err_d;
  logic       last_id_q, last_id_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       can_accept;
  logic       grant;
  logic       accept;
  logic [3:0] sel_bcd;
  logic       sel_err;

  always_comb begin
    // rst_n gates acceptance so no ready leaks out while reset is held
    can_accept = rst_n && ((state_q == EMPTY) || out_ready);
    if (req0_valid && req1_valid) begin
      grant = (FAIR != 0) ? ~last_id_q : 1'b0;
    end else begin
      grant = req1_valid;
    end
    req0_ready = can_accept && req0_valid && !grant;
    req1_ready = can_accept && req1_valid && grant;
    accept     = req0_ready || req1_ready;
    sel_bcd    = grant ? req1_bcd : req0_bcd;
    sel_err    = (sel_bcd > 4'd9);
  end

  always_comb begin
    state_d    = state_q;
    out_gray_d = out_gray_q;
    out_id_d   = out_id_q;
    out_err_d  = out_err_q;
    last_id_d  = last_id_q;
    err_cnt_d  = err_cnt_q;
    if (accept) begin
      state_d   = FULL;
      out_id_d  = grant;
      last_id_d = grant;
      out_err_d = sel_err;
      if (sel_err) begin
        out_gray_d = 4'b0000;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end else begin
        out_gray_d = {sel_bcd[3], sel_bcd[3] ^ sel_bcd[2],
                      sel_bcd[2] ^ sel_bcd[1], sel_bcd[1] ^ sel_bcd[0]};
      end
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_gray_q <= 4'b0000;
      out_id_q   <= 1'b0;
      out_err_q  <= 1'b0;
      last_id_q  <= 1'b1;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      out_gray_q <= out_gray_d;
      out_id_q   <= out_id_d;
      out_err_q  <= out_err_d;
      last_id_q  <= last_id_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_gray  = out_gray_q;
  assign out_id    = out_id_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
